// File: rtl/response_capture_unit_pkg.sv
// Shared definitions for the response capture unit: FSM encoding and default
// sample/signature parameters.
package response_capture_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int          DATA_W_DEF   = 7;
  localparam int          SIG_W_DEF    = 16;
  localparam logic [15:0] SIG_SEED_DEF = 16'hFFFF;
  localparam logic [15:0] POLY_DEF     = 16'h1021;

endpackage

// File: rtl/response_capture_unit_sync_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty; a push while full
// is accepted only when the same cycle also pops, otherwise it is reported as dropped.
module sync_fifo #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              drop
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              pop_s;
  logic              push_s;

  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s  = pop && !empty;
  assign push_s = push && (!full || pop_s);
  assign drop   = push && full && !pop_s;
  assign rdata  = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write; read data only becomes visible after the write edge.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/response_capture_unit.sv
// Captures {count, result} beats of a run, compacts them into a MISR signature
// and buffers them for a valid/ready consumer.
module response_capture_unit
  import response_capture_unit_pkg::*;
#(
  parameter int               DATA_W   = DATA_W_DEF,
  parameter int               DEPTH    = 16,
  parameter int               SIG_W    = SIG_W_DEF,
  parameter logic [SIG_W-1:0] SIG_SEED = SIG_SEED_DEF,
  parameter logic [SIG_W-1:0] POLY     = POLY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       sample_limit,
  input  logic              in_valid,
  input  logic [5:0]        count,
  input  logic              result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SIG_W-1:0]  signature,
  output logic [15:0]       sample_cnt,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  state_t            state_r;
  logic [15:0]       limit_r;
  logic [DATA_W-1:0] sample_s;
  logic [SIG_W-1:0]  sig_next_s;
  logic [15:0]       cnt_next_s;
  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_drop_s;

  assign sample_s    = {count, result};
  assign cnt_next_s  = sample_cnt + 16'd1;
  assign fifo_push_s = (state_r == ST_CAPTURE) && in_valid;
  assign fifo_pop_s  = out_valid && out_ready;
  assign out_valid   = !fifo_empty_s;

  // MISR next value for the current beat.
  always_comb begin
    sig_next_s = {signature[SIG_W-2:0], 1'b0} ^ {{(SIG_W-DATA_W){1'b0}}, sample_s};
    if (signature[SIG_W-1]) begin
      sig_next_s = sig_next_s ^ POLY;
    end else begin
      sig_next_s = sig_next_s;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .wdata (sample_s),
    .rdata (out_data),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .drop  (fifo_drop_s)
  );

  // Run control, sample counter and signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      limit_r    <= 16'd0;
      sample_cnt <= 16'd0;
      signature  <= SIG_SEED;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            limit_r    <= sample_limit;
            sample_cnt <= 16'd0;
            overflow   <= 1'b0;
            signature  <= SIG_SEED;
            busy       <= 1'b1;
            state_r    <= (sample_limit == 16'd0) ? ST_FLUSH : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (in_valid) begin
            sample_cnt <= cnt_next_s;
            signature  <= sig_next_s;
            if (fifo_drop_s) begin
              overflow <= 1'b1;
            end
            if (cnt_next_s == limit_r) begin
              state_r <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (fifo_empty_s) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // The FIFO full flag is only consumed through its drop indication.
  logic unused_s;
  assign unused_s = fifo_full_s;

endmodule

// File: tb/tb_response_capture_unit.sv
// Randomized bench for response_capture_unit with a queue-based reference model
// and a few hand-computed expectations.
module tb_response_capture_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] sample_limit;
  logic        in_valid;
  logic [5:0]  count;
  logic        result;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_data;
  logic [15:0] signature;
  logic [15:0] sample_cnt;
  logic        busy;
  logic        done;
  logic        overflow;

  always #5 clk = ~clk;

  response_capture_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sample_limit (sample_limit),
    .in_valid     (in_valid),
    .count        (count),
    .result       (result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .signature    (signature),
    .sample_cnt   (sample_cnt),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: run phase 0 idle, 1 capture, 2 flush, 3 done.
  logic [6:0]  mq[$];
  int          mphase;
  logic [15:0] msig;
  logic [15:0] mcnt;
  logic [15:0] mlimit;
  logic        mov;
  logic        mdone;
  logic        mbusy;

  function automatic logic [15:0] m_misr(input logic [15:0] s, input logic [6:0] d);
    logic [16:0] t;
    t = {s, 1'b0};
    if (t[16]) t = t ^ 17'h11021;
    return t[15:0] ^ {9'd0, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mphase = 0;
    msig   = 16'hFFFF;
    mcnt   = 16'd0;
    mlimit = 16'd0;
    mov    = 1'b0;
    mdone  = 1'b0;
    mbusy  = 1'b0;
  endtask

  task automatic model_step();
    int pre;
    bit popped;
    pre = mq.size();
    popped = (pre > 0) && out_ready;
    if (popped) void'(mq.pop_front());
    case (mphase)
      0: begin
        mdone = 1'b0;
        if (start) begin
          mlimit = sample_limit;
          mcnt   = 16'd0;
          mov    = 1'b0;
          msig   = 16'hFFFF;
          mbusy  = 1'b1;
          mphase = (sample_limit == 16'd0) ? 2 : 1;
        end
      end
      1: begin
        if (in_valid) begin
          mcnt = mcnt + 16'd1;
          msig = m_misr(msig, {count, result});
          if (pre < 16 || popped) mq.push_back({count, result});
          else mov = 1'b1;
          if (mcnt == mlimit) mphase = 2;
        end
      end
      2: begin
        if (pre == 0) begin
          mphase = 3;
          mdone  = 1'b1;
        end
      end
      default: begin
        mphase = 0;
        mdone  = 1'b0;
        mbusy  = 1'b0;
      end
    endcase
  endtask

  task automatic compare_all();
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) chk("out_data", out_data, mq[0]);
    chk("signature", signature, msig);
    chk("sample_cnt", sample_cnt, mcnt);
    chk("busy", busy, mbusy);
    chk("done", done, mdone);
    chk("overflow", overflow, mov);
  endtask

  // One clock: the model advances with the DUT edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_start(input logic [15:0] lim);
    start = 1'b1;
    sample_limit = lim;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    chk(name, seen, 1'b1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sample_limit = 16'd0;
    in_valid = 1'b0;
    count = 6'd0;
    result = 1'b0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_sig", signature, 16'hFFFF);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single beat of zero.
    do_start(16'd1);
    in_valid = 1'b1; count = 6'd0; result = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("t1_sig", signature, 16'hEFDF);
    chk("t1_cnt", sample_cnt, 16'd1);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 7'h00);
    wait_done("t1_done", 20);

    // Empty run; in_valid must be ignored.
    in_valid = 1'b1;
    do_start(16'd0);
    wait_done("t2_done", 20);
    in_valid = 1'b0;
    chk("t2_sig", signature, 16'hFFFF);
    chk("t2_cnt", sample_cnt, 16'd0);
    chk("t2_nodata", out_valid, 1'b0);

    // Overflow with a stalled consumer.
    out_ready = 1'b0;
    do_start(16'd18);
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; count = 6'(i); result = i[0];
      tick();
    end
    in_valid = 1'b0;
    chk("t3_ov", overflow, 1'b1);
    chk("t3_cnt", sample_cnt, 16'd18);
    chk("t3_first", out_data, 7'h00);
    out_ready = 1'b1;
    wait_done("t3_done", 40);

    // Full FIFO with simultaneous push and pop across pointer wrap.
    out_ready = 1'b0;
    do_start(16'd40);
    for (int i = 0; i < 40; i++) begin
      if (i == 16) out_ready = 1'b1;
      in_valid = 1'b1; count = 6'(i + 3); result = i[1];
      tick();
    end
    in_valid = 1'b0;
    chk("t4_ov", overflow, 1'b0);
    chk("t4_cnt", sample_cnt, 16'd40);
    wait_done("t4_done", 60);

    // Long random run with backpressure.
    do_start(16'd5000);
    for (int i = 0; i < 20000 && mphase == 1; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      count     = 6'($urandom);
      result    = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("t5_cnt", sample_cnt, 16'd5000);
    wait_done("t5_done", 100);

    // Restart ignored while busy, then asynchronous abort.
    do_start(16'd100);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; count = 6'(i * 7); result = 1'b1;
      tick();
    end
    start = 1'b1; sample_limit = 16'd3;
    tick();
    start = 1'b0;
    tick();
    chk("t6_busy", busy, 1'b1);
    chk("t6_cnt", sample_cnt, 16'd7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_sig", signature, 16'hFFFF);
    chk("t6_busy0", busy, 1'b0);
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_cnt0", sample_cnt, 16'd0);
    chk("t6_ov", overflow, 1'b0);
    chk("t6_done", done, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
